// File: rtl/ecg_infer_ctrl_if.sv
// Control/result bundle between the ECG inference sequencer, the six pipeline
// stages and the host. The controller takes the slave view; the environment takes the master view.
interface ecg_infer_ctrl_if #(
    parameter int NUM_BLK = 6,
    parameter int CNT_W   = 20
);
    // No valid/ready pairs: start, abort, stage_val and class_val are one-cycle
    // strobes sampled on every rising clock edge and are never back-pressured.
    // done is a one-cycle strobe qualifying class_out.
    logic               start;
    logic               abort;
    logic [NUM_BLK-2:0] stage_val;
    logic [2:0]         class_in;
    logic               class_val;
    logic [NUM_BLK-1:0] blk_rst_n;
    logic               busy;
    logic               done;
    logic [2:0]         class_out;
    logic               timeout_err;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [1:0]         state_dbg;

    modport master (
        output start, abort, stage_val, class_in, class_val,
        input  blk_rst_n, busy, done, class_out, timeout_err, cycle_cnt, state_dbg
    );

    modport slave (
        input  start, abort, stage_val, class_in, class_val,
        output blk_rst_n, busy, done, class_out, timeout_err, cycle_cnt, state_dbg
    );
endinterface

// File: rtl/ecg_infer_ctrl.sv
// Inference sequencer: releases pipeline stage resets in order, bounds each run
// with a timeout and latches the final class with a one-cycle done pulse.
module ecg_infer_ctrl #(
    parameter int NUM_BLK = 6,
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    ecg_infer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [NUM_BLK-1:0] REL_FIRST = {{(NUM_BLK-1){1'b0}}, 1'b1};

    state_t             state;
    logic [NUM_BLK-1:0] rel_next;
    logic               class_ok;
    logic               timeout_hit;

    // blk_rst_n doubles as the release mask; each stage_val bit is judged
    // against the current mask only, so at most one new stage per cycle.
    always_comb begin
        rel_next = bus.blk_rst_n;
        for (int i = 1; i < NUM_BLK; i++) begin
            if (bus.stage_val[i-1] && bus.blk_rst_n[i-1]) begin
                rel_next[i] = 1'b1;
            end
        end
    end

    assign class_ok    = bus.class_val && bus.blk_rst_n[NUM_BLK-1];
    assign timeout_hit = (bus.cycle_cnt == CNT_LAST);
    assign bus.state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.blk_rst_n   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.class_out   <= 3'd0;
            bus.timeout_err <= 1'b0;
            bus.cycle_cnt   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state           <= RUN;
                        bus.blk_rst_n   <= REL_FIRST;
                        bus.busy        <= 1'b1;
                        bus.cycle_cnt   <= '0;
                        bus.timeout_err <= 1'b0;
                    end
                end
                RUN: begin
                    bus.cycle_cnt <= bus.cycle_cnt + CNT_W'(1);
                    if (bus.abort) begin
                        state         <= IDLE;
                        bus.blk_rst_n <= '0;
                        bus.busy      <= 1'b0;
                    end else if (class_ok) begin
                        state         <= DONE;
                        bus.class_out <= bus.class_in;
                        bus.done      <= 1'b1;
                        bus.blk_rst_n <= '0;
                        bus.busy      <= 1'b0;
                    end else if (timeout_hit) begin
                        state           <= ERR;
                        bus.timeout_err <= 1'b1;
                        bus.blk_rst_n   <= '0;
                        bus.busy        <= 1'b0;
                    end else begin
                        bus.blk_rst_n <= rel_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    // Error flag survives an abort so the host can still read it.
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.start) begin
                        state           <= RUN;
                        bus.blk_rst_n   <= REL_FIRST;
                        bus.busy        <= 1'b1;
                        bus.cycle_cnt   <= '0;
                        bus.timeout_err <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
